// File: rtl/circuito_exp7.sv
`default_nettype none
// ============================================================================
//  Module      : circuito_exp7
//  Description : Genius/Simon memory game controller. A 16x4 sequence memory
//                is shown on four LEDs and repeated on four one-hot buttons,
//                round by round. Mode 1 replays the growing sequence every
//                round; mode 2 shows only round 1 and appends a player-chosen
//                value after each correct round. Includes the control FSM,
//                counters, timers, edge detection and 7-segment debug outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module circuito_exp7 #(
  parameter int CLOCK_FREQ = 5000,
  parameter int TM         = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  input  logic       nivel_jogadas,
  input  logic       nivel_tempo,
  input  logic       modo2,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       vez_jogador,
  output logic       nova_jogada,
  output logic [3:0] leds,
  output logic       pulso_buzzer,
  output logic       db_jogada_correta,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_jogada,
  output logic [6:0] db_rodada,
  output logic [6:0] db_estado_lsb,
  output logic [6:0] db_estado_msb,
  output logic       db_nivel_jogadas,
  output logic       db_nivel_tempo,
  output logic       db_clock,
  output logic       db_enderecoIgualRodada,
  output logic       db_timeout
);

  // --------------------------------------------------------------------------
  // Timer limits. Every timer counts from 0 up to (duration - 1).
  // --------------------------------------------------------------------------
  localparam int c_T_MEIO   = CLOCK_FREQ / 2;
  localparam int c_T_MOSTRA = TM * CLOCK_FREQ;
  localparam int c_T_TMO5   = 5 * CLOCK_FREQ;
  localparam int c_T_TMO3   = 3 * CLOCK_FREQ;
  localparam int c_T_MAX    = (c_T_MOSTRA > c_T_TMO5) ? c_T_MOSTRA : c_T_TMO5;
  localparam int c_TW       = $clog2(c_T_MAX + 1);

  localparam logic [c_TW-1:0] c_LIM_MEIO   = c_TW'(c_T_MEIO - 1);
  localparam logic [c_TW-1:0] c_LIM_MOSTRA = c_TW'(c_T_MOSTRA - 1);
  localparam logic [c_TW-1:0] c_LIM_TMO5   = c_TW'(c_T_TMO5 - 1);
  localparam logic [c_TW-1:0] c_LIM_TMO3   = c_TW'(c_T_TMO3 - 1);
  localparam logic [c_TW-1:0] c_TMR_UM     = c_TW'(1);

  // State codes are visible on the debug displays, so they are fixed here.
  typedef enum logic [3:0] {
    S_INICIAL       = 4'h0,
    S_PREPARACAO    = 4'h1,
    S_INICIO_RODADA = 4'h2,
    S_MOSTRA        = 4'h3,
    S_INTERVALO     = 4'h4,
    S_PROX_MOSTRA   = 4'h5,
    S_ESPERA_JOGADA = 4'h6,
    S_REGISTRA      = 4'h7,
    S_COMPARA       = 4'h8,
    S_PROX_JOGADA   = 4'h9,
    S_PROX_RODADA   = 4'hA,
    S_ESPERA_NOVA   = 4'hB,
    S_GRAVA         = 4'hC,
    S_FIM_GANHOU    = 4'hD,
    S_FIM_PERDEU    = 4'hE,
    S_FIM_TIMEOUT   = 4'hF
  } t_estado;

  // Active-low gfedcba hexadecimal display decoder
  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  t_estado         r_estado;
  logic [3:0]      r_endereco;
  logic [3:0]      r_rodada;
  logic [3:0]      r_jogada;
  logic            r_nivel_jogadas;
  logic            r_nivel_tempo;
  logic            r_modo2;
  logic [c_TW-1:0] r_tmr;        // presentation / pause timer
  logic [c_TW-1:0] r_tmo;        // play timeout counter
  logic            r_timeout;
  logic            r_fase_nova;  // the pending registra belongs to espera_nova
  logic            r_iniciar_ant;
  logic            r_botoes_ant;

  // Power-up contents mirror valores.dat; writes persist across resets.
  logic [3:0] r_mem [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 4'h1, 4'h8, 4'h4,
                             4'h4, 4'h8, 4'h1, 4'h2, 4'h8, 4'h4, 4'h2, 4'h1};

  logic [3:0]      w_mem_dado;
  logic [3:0]      w_end_grava;
  logic            w_inicio;
  logic            w_jogada;
  logic            w_correta;
  logic            w_end_eq_rod;
  logic            w_ultima;
  logic [c_TW-1:0] w_lim_tmo;
  logic [3:0]      w_leds;

  assign w_mem_dado   = r_mem[r_endereco];
  assign w_end_grava  = r_rodada + 4'd1;   // wraps to 0 after round 16
  assign w_inicio     = iniciar & ~r_iniciar_ant;
  assign w_jogada     = (|botoes) & ~r_botoes_ant;
  assign w_correta    = (r_jogada == w_mem_dado);
  assign w_end_eq_rod = (r_endereco == r_rodada);
  assign w_ultima     = r_nivel_jogadas ? (r_rodada == 4'hF) : (r_rodada == 4'h7);
  assign w_lim_tmo    = r_nivel_tempo ? c_LIM_TMO3 : c_LIM_TMO5;

  // Previous-cycle samples of iniciar and any-button for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_iniciar_ant <= 1'b0;
      r_botoes_ant  <= 1'b0;
    end else begin
      r_iniciar_ant <= iniciar;
      r_botoes_ant  <= |botoes;
    end
  end

  // Sequence memory write port: new mode-2 value goes after the current round
  always_ff @(posedge clock) begin
    if (r_estado == S_GRAVA) begin
      r_mem[w_end_grava] <= r_jogada;
    end
  end

  // Control FSM together with the counters and timers it steers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado        <= S_INICIAL;
      r_endereco      <= 4'h0;
      r_rodada        <= 4'h0;
      r_jogada        <= 4'h0;
      r_nivel_jogadas <= 1'b0;
      r_nivel_tempo   <= 1'b0;
      r_modo2         <= 1'b0;
      r_tmr           <= '0;
      r_tmo           <= '0;
      r_timeout       <= 1'b0;
      r_fase_nova     <= 1'b0;
    end else begin
      case (r_estado)
        S_INICIAL: begin
          if (w_inicio) r_estado <= S_PREPARACAO;
        end

        S_PREPARACAO: begin
          r_endereco      <= 4'h0;
          r_rodada        <= 4'h0;
          r_jogada        <= 4'h0;
          r_tmr           <= '0;
          r_tmo           <= '0;
          r_timeout       <= 1'b0;
          r_fase_nova     <= 1'b0;
          r_nivel_jogadas <= nivel_jogadas;
          r_nivel_tempo   <= nivel_tempo;
          r_modo2         <= modo2;
          r_estado        <= S_INICIO_RODADA;
        end

        S_INICIO_RODADA: begin
          r_endereco <= 4'h0;
          if (r_tmr == c_LIM_MEIO) begin
            r_tmr    <= '0;
            r_estado <= S_MOSTRA;
          end else begin
            r_tmr <= r_tmr + c_TMR_UM;
          end
        end

        S_MOSTRA: begin
          if (r_tmr == c_LIM_MOSTRA) begin
            r_tmr    <= '0;
            r_estado <= S_INTERVALO;
          end else begin
            r_tmr <= r_tmr + c_TMR_UM;
          end
        end

        S_INTERVALO: begin
          if (r_tmr == c_LIM_MEIO) begin
            r_tmr <= '0;
            if (w_end_eq_rod) begin
              // Presentation done: the player restarts from the first element
              r_endereco <= 4'h0;
              r_tmo      <= '0;
              r_estado   <= S_ESPERA_JOGADA;
            end else begin
              r_estado <= S_PROX_MOSTRA;
            end
          end else begin
            r_tmr <= r_tmr + c_TMR_UM;
          end
        end

        S_PROX_MOSTRA: begin
          r_endereco <= r_endereco + 4'd1;
          r_estado   <= S_MOSTRA;
        end

        S_ESPERA_JOGADA, S_ESPERA_NOVA: begin
          if (w_jogada) begin
            r_estado <= S_REGISTRA;
          end else if (r_tmo == w_lim_tmo) begin
            r_timeout <= 1'b1;
            r_estado  <= S_FIM_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + c_TMR_UM;
          end
        end

        S_REGISTRA: begin
          r_jogada <= botoes;
          r_estado <= r_fase_nova ? S_GRAVA : S_COMPARA;
        end

        S_COMPARA: begin
          if (!w_correta) begin
            r_estado <= S_FIM_PERDEU;
          end else if (!w_end_eq_rod) begin
            r_estado <= S_PROX_JOGADA;
          end else if (r_modo2) begin
            r_fase_nova <= 1'b1;
            r_tmo       <= '0;
            r_estado    <= S_ESPERA_NOVA;
          end else if (w_ultima) begin
            r_estado <= S_FIM_GANHOU;
          end else begin
            r_estado <= S_PROX_RODADA;
          end
        end

        S_PROX_JOGADA: begin
          r_endereco <= r_endereco + 4'd1;
          r_tmo      <= '0;
          r_estado   <= S_ESPERA_JOGADA;
        end

        S_PROX_RODADA: begin
          r_rodada <= r_rodada + 4'd1;
          if (r_modo2) begin
            // Mode 2 skips the presentation after the first round
            r_endereco <= 4'h0;
            r_tmo      <= '0;
            r_estado   <= S_ESPERA_JOGADA;
          end else begin
            r_tmr    <= '0;
            r_estado <= S_INICIO_RODADA;
          end
        end

        S_GRAVA: begin
          r_fase_nova <= 1'b0;
          r_estado    <= w_ultima ? S_FIM_GANHOU : S_PROX_RODADA;
        end

        S_FIM_GANHOU, S_FIM_PERDEU, S_FIM_TIMEOUT: begin
          if (w_inicio) r_estado <= S_PREPARACAO;
        end

        default: r_estado <= S_INICIAL;
      endcase
    end
  end

  // LED source: memory during presentation, button echo otherwise, dark when idle
  always_comb begin
    w_leds = 4'h0;
    if (r_estado == S_MOSTRA) begin
      w_leds = w_mem_dado;
    end else if (r_estado != S_INICIAL) begin
      w_leds = botoes;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the state register
  // --------------------------------------------------------------------------
  assign ganhou       = (r_estado == S_FIM_GANHOU);
  assign perdeu       = (r_estado == S_FIM_PERDEU) || (r_estado == S_FIM_TIMEOUT);
  assign pronto       = (r_estado == S_FIM_GANHOU) || (r_estado == S_FIM_PERDEU) ||
                        (r_estado == S_FIM_TIMEOUT);
  assign vez_jogador  = (r_estado == S_ESPERA_JOGADA);
  assign nova_jogada  = (r_estado == S_ESPERA_NOVA);
  assign leds         = w_leds;
  assign pulso_buzzer = |w_leds;

  assign db_jogada_correta      = w_correta;
  assign db_contagem            = f_hex7(r_endereco);
  assign db_memoria             = f_hex7(w_mem_dado);
  assign db_jogada              = f_hex7(r_jogada);
  assign db_rodada              = f_hex7(r_rodada);
  assign db_estado_lsb          = f_hex7(r_estado);
  assign db_estado_msb          = f_hex7(4'h0);   // state code fits in one nibble
  assign db_nivel_jogadas       = r_nivel_jogadas;
  assign db_nivel_tempo         = r_nivel_tempo;
  assign db_clock               = clock;
  assign db_enderecoIgualRodada = w_end_eq_rod;
  assign db_timeout             = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_circuito_exp7.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circuito_exp7
//  Description : Directed self-checking bench for the memory game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circuito_exp7;

  localparam int CF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic       nivel_jogadas = 1'b0;
  logic       nivel_tempo = 1'b0;
  logic       modo2 = 1'b0;

  logic       ganhou, perdeu, pronto, vez_jogador, nova_jogada;
  logic [3:0] leds;
  logic       pulso_buzzer, db_jogada_correta;
  logic [6:0] db_contagem, db_memoria, db_jogada, db_rodada;
  logic [6:0] db_estado_lsb, db_estado_msb;
  logic       db_nivel_jogadas, db_nivel_tempo, db_clock;
  logic       db_enderecoIgualRodada, db_timeout;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_mem [16];

  always #5 clock = ~clock;

  circuito_exp7 #(.CLOCK_FREQ(CF), .TM(1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .nivel_jogadas(nivel_jogadas), .nivel_tempo(nivel_tempo), .modo2(modo2),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .vez_jogador(vez_jogador), .nova_jogada(nova_jogada), .leds(leds),
    .pulso_buzzer(pulso_buzzer), .db_jogada_correta(db_jogada_correta),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogada(db_jogada),
    .db_rodada(db_rodada), .db_estado_lsb(db_estado_lsb),
    .db_estado_msb(db_estado_msb), .db_nivel_jogadas(db_nivel_jogadas),
    .db_nivel_tempo(db_nivel_tempo), .db_clock(db_clock),
    .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_timeout(db_timeout)
  );

  // Expected 7-segment patterns (active-low gfedcba)
  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Waits for vez_jogador or nova_jogada; checks each presented LED value
  task automatic wait_ready(output int shown);
    int  n;
    logic was;
    shown = 0; n = 0; was = 1'b0;
    while (!(vez_jogador || nova_jogada) && n < 2000) begin
      if (db_estado_lsb == seg(4'h3) && !was) begin
        checks++;
        if (shown > 15 || leds !== exp_mem[shown[3:0]]) begin
          errors++;
          $display("FAIL show[%0d]: leds=%b expected %b", shown, leds, exp_mem[shown[3:0]]);
        end
        shown++;
      end
      was = (db_estado_lsb == seg(4'h3));
      @(negedge clock); n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_ready: no play state after %0d cycles, expected one", n);
    end
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    #1;
    checks++;
    if (leds !== v || pulso_buzzer !== 1'b1) begin
      errors++;
      $display("FAIL echo: leds=%b buzzer=%b expected %b/1", leds, pulso_buzzer, v);
    end
    @(negedge clock); @(negedge clock); @(negedge clock);
    botoes = 4'h0;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!pronto && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (!pronto) begin
      errors++;
      $display("FAIL wait_end: pronto=%b after %0d cycles, expected 1", pronto, n);
    end
  endtask

  task automatic start_game(input logic nj, input logic nt, input logic m2);
    nivel_jogadas = nj; nivel_tempo = nt; modo2 = m2;
    iniciar = 1'b1;
    @(negedge clock); @(negedge clock); @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  // One round r (1-based): wait, verify presentation count, repeat sequence
  task automatic play_round(input int r, input int exp_shown);
    int sh;
    wait_ready(sh);
    checks++;
    if (sh !== exp_shown) begin
      errors++;
      $display("FAIL shown_r%0d: %0d values shown, expected %0d", r, sh, exp_shown);
    end
    for (int i = 0; i < r; i++) begin
      if (i > 0) wait_ready(sh);
      press(exp_mem[i]);
    end
  endtask

  // Mode 2 tail of round r: enter the new value written at address r mod 16
  task automatic new_value(input int r);
    int sh;
    logic [3:0] nv;
    wait_ready(sh);
    checks++;
    if (nova_jogada !== 1'b1 || vez_jogador !== 1'b0) begin
      errors++;
      $display("FAIL nova_r%0d: nova=%b vez=%b expected 1/0", r, nova_jogada, vez_jogador);
    end
    nv = rot(exp_mem[r % 16]);
    exp_mem[r % 16] = nv;
    press(nv);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock); @(negedge clock);
    checks++;
    if ({ganhou, perdeu, pronto, vez_jogador, nova_jogada, pulso_buzzer,
         db_timeout, db_jogada_correta, db_nivel_jogadas, db_nivel_tempo} !== 10'b0) begin
      errors++;
      $display("FAIL reset_flags: %b expected 0000000000",
               {ganhou, perdeu, pronto, vez_jogador, nova_jogada, pulso_buzzer,
                db_timeout, db_jogada_correta, db_nivel_jogadas, db_nivel_tempo});
    end
    checks++;
    if (leds !== 4'h0 || db_estado_lsb !== seg(4'h0) || db_estado_msb !== seg(4'h0)) begin
      errors++;
      $display("FAIL reset_state: leds=%b est=%b/%b expected 0000/%b", leds,
               db_estado_lsb, db_estado_msb, seg(4'h0));
    end
    checks++;
    if (db_contagem !== seg(4'h0) || db_rodada !== seg(4'h0) || db_jogada !== seg(4'h0) ||
        db_memoria !== seg(exp_mem[0])) begin
      errors++;
      $display("FAIL reset_db: cont=%b rod=%b jog=%b mem=%b", db_contagem, db_rodada,
               db_jogada, db_memoria);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_modo1_n0();
    start_game(1'b0, 1'b0, 1'b0);
    for (int r = 1; r <= 8; r++) play_round(r, r);
    wait_end();
    checks++;
    if (ganhou !== 1'b1 || perdeu !== 1'b0 || db_estado_lsb !== seg(4'hD) ||
        db_rodada !== seg(4'h7) || db_nivel_jogadas !== 1'b0) begin
      errors++;
      $display("FAIL modo1_n0: g=%b p=%b est=%b rod=%b nj=%b expected 1/0/%b/%b/0",
               ganhou, perdeu, db_estado_lsb, db_rodada, db_nivel_jogadas, seg(4'hD), seg(4'h7));
    end
  endtask

  task automatic test_modo1_n1();
    start_game(1'b1, 1'b0, 1'b0);
    for (int r = 1; r <= 16; r++) play_round(r, r);
    wait_end();
    checks++;
    if (ganhou !== 1'b1 || pronto !== 1'b1 || db_rodada !== seg(4'hF) ||
        db_nivel_jogadas !== 1'b1) begin
      errors++;
      $display("FAIL modo1_n1: g=%b pr=%b rod=%b nj=%b expected 1/1/%b/1",
               ganhou, pronto, db_rodada, db_nivel_jogadas, seg(4'hF));
    end
  endtask

  task automatic test_perde();
    int sh;
    start_game(1'b1, 1'b0, 1'b0);
    for (int r = 1; r <= 6; r++) play_round(r, r);
    wait_ready(sh);
    checks++;
    if (sh !== 7) begin
      errors++;
      $display("FAIL perde_shown: %0d expected 7", sh);
    end
    press(4'b0010);
    wait_end();
    checks++;
    if (perdeu !== 1'b1 || ganhou !== 1'b0 || db_estado_lsb !== seg(4'hE) ||
        db_jogada !== seg(4'h2) || db_timeout !== 1'b0) begin
      errors++;
      $display("FAIL perde: p=%b g=%b est=%b jog=%b to=%b expected 1/0/%b/%b/0",
               perdeu, ganhou, db_estado_lsb, db_jogada, db_timeout, seg(4'hE), seg(4'h2));
    end
  endtask

  task automatic test_modo2();
    start_game(1'b1, 1'b0, 1'b1);
    for (int r = 1; r <= 16; r++) begin
      play_round(r, (r == 1) ? 1 : 0);
      new_value(r);
    end
    wait_end();
    checks++;
    if (ganhou !== 1'b1 || pronto !== 1'b1 || db_estado_lsb !== seg(4'hD) ||
        db_rodada !== seg(4'hF)) begin
      errors++;
      $display("FAIL modo2: g=%b pr=%b est=%b rod=%b expected 1/1/%b/%b",
               ganhou, pronto, db_estado_lsb, db_rodada, seg(4'hD), seg(4'hF));
    end
  endtask

  task automatic test_modo2_perde();
    int sh;
    start_game(1'b0, 1'b0, 1'b1);
    // round 1 shows mem[0], which the previous game rewrote by wrap-around
    for (int r = 1; r <= 6; r++) begin
      play_round(r, (r == 1) ? 1 : 0);
      new_value(r);
    end
    wait_ready(sh);
    press(rot(exp_mem[0]));
    wait_end();
    checks++;
    if (perdeu !== 1'b1 || pronto !== 1'b1 || ganhou !== 1'b0 ||
        db_estado_lsb !== seg(4'hE)) begin
      errors++;
      $display("FAIL modo2_perde: p=%b pr=%b g=%b est=%b expected 1/1/0/%b",
               perdeu, pronto, ganhou, db_estado_lsb, seg(4'hE));
    end
  endtask

  task automatic test_timeout(input logic nt, input int exp_cycles);
    int sh, n;
    start_game(1'b0, nt, 1'b0);
    wait_ready(sh);
    n = 0;
    while (!pronto && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (n !== exp_cycles) begin
      errors++;
      $display("FAIL timeout_len_nt%0b: %0d cycles expected %0d", nt, n, exp_cycles);
    end
    checks++;
    if (db_timeout !== 1'b1 || perdeu !== 1'b1 || db_estado_lsb !== seg(4'hF) ||
        db_nivel_tempo !== nt) begin
      errors++;
      $display("FAIL timeout_nt%0b: to=%b p=%b est=%b nt=%b expected 1/1/%b/%b",
               nt, db_timeout, perdeu, db_estado_lsb, db_nivel_tempo, seg(4'hF), nt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_game(1'b1, 1'b1, 1'b0);
    n = 0;
    while (db_estado_lsb !== seg(4'h3) && n < 200) begin @(negedge clock); n++; end
    checks++;
    if (leds !== exp_mem[0] || pulso_buzzer !== 1'b1) begin
      errors++;
      $display("FAIL mid_show: leds=%b buzzer=%b expected %b/1", leds, pulso_buzzer, exp_mem[0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ganhou, perdeu, pronto, vez_jogador, nova_jogada, pulso_buzzer, db_timeout,
         db_nivel_jogadas, db_nivel_tempo} !== 9'b0 || leds !== 4'h0 ||
        db_estado_lsb !== seg(4'h0) || db_contagem !== seg(4'h0)) begin
      errors++;
      $display("FAIL reset_mid: flags=%b leds=%b est=%b cont=%b expected 0/0000/%b/%b",
               {ganhou, perdeu, pronto, vez_jogador, nova_jogada, pulso_buzzer, db_timeout,
                db_nivel_jogadas, db_nivel_tempo}, leds, db_estado_lsb, db_contagem,
               seg(4'h0), seg(4'h0));
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    exp_mem = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 4'h1, 4'h8, 4'h4,
                4'h4, 4'h8, 4'h1, 4'h2, 4'h8, 4'h4, 4'h2, 4'h1};
    test_reset();
    test_modo1_n0();
    test_modo1_n1();
    test_perde();
    test_modo2();
    test_modo2_perde();
    test_timeout(1'b0, 5 * CF);
    test_timeout(1'b1, 3 * CF);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/circuito_exp7.md
Name: circuito_exp7

Overview:
Top-level controller for a Genius/Simon-style memory game in FPGA. A 16-entry sequence memory is shown on 4 LEDs and the player repeats it on 4 one-hot buttons, round by round. Mode 1 presents the growing sequence every round. Mode 2 presents only round 1; after each correct round the player enters a new value, which is written as the next sequence element. Includes control FSM, datapath (counters, memory, timers), edge detection and 7-segment debug outputs.

Parameters:
CLOCK_FREQ, 5000, clock cycles per "second" (timer base).
TM, 1, LED on-time multiplier in seconds.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start game; level held ≥2 cycles; acted on at rising edge
botoes  in  4  player buttons, one-hot
nivel_jogadas  in  1  0: 8 rounds; 1: 16 rounds; latched at start
nivel_tempo  in  1  0: play timeout 5·CLOCK_FREQ; 1: 3·CLOCK_FREQ; latched at start
modo2  in  1  0: mode 1; 1: mode 2; latched at start
ganhou  out  1  game won
perdeu  out  1  game lost (wrong play or timeout)
pronto  out  1  game finished
vez_jogador  out  1  waiting for a sequence play
nova_jogada  out  1  mode 2: waiting for the new value
leds  out  4  presentation value, or echo of botoes while pressed
pulso_buzzer  out  1  high whenever leds≠0
db_jogada_correta  out  1  latched play == memory[endereco]
db_contagem, db_memoria, db_jogada, db_rodada  out  7 each  7-seg of address, memory data, latched play, round counter
db_estado_lsb, db_estado_msb  out  7 each  7-seg of FSM state code, low/high nibble
db_nivel_jogadas, db_nivel_tempo  out  1 each  latched levels
db_clock  out  1  copy of clock
db_enderecoIgualRodada  out  1  endereco == rodada
db_timeout  out  1  play timeout expired

Behaviour:
- 7-seg encoding is active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- Reset (reset=0): FSM→inicial; counters, latched levels, jogada and timers cleared; all 1-bit outputs 0; leds=0.
- Memory: 16×4, power-up contents from valores.dat. Writes persist; reset does not reload. Read address = endereco counter (0..15). Rodada counter 0..15. Round r (1-based) = rodada+1.
- States (code): inicial 0; preparacao 1 (clear counters; latch nivel_jogadas, nivel_tempo, modo2); inicio_rodada 2 (pause CLOCK_FREQ/2, endereco=0); mostra 3 (leds=mem[endereco] for TM·CLOCK_FREQ cycles); intervalo 4 (leds=0 for CLOCK_FREQ/2); prox_mostra 5 (endereco++, back to mostra, until endereco==rodada); espera_jogada 6 (endereco=0 on entry, vez_jogador=1, timeout counter running); registra 7 (latch botoes into jogada); compara 8; prox_jogada 9 (endereco++); prox_rodada A (rodada++); espera_nova B; grava C (mem[rodada+1]=jogada); fim_ganhou D; fim_perdeu E; fim_timeout F.
- Play detection: rising edge of OR(botoes) in espera_jogada/espera_nova → registra. A held button counts once.
- Compare: wrong → fim_perdeu. Correct with endereco≠rodada → prox_jogada → espera_jogada (timeout restarts).
- Correct with endereco==rodada: mode 1 → last round (rodada==7 or 15 by level)? fim_ganhou : prox_rodada → inicio_rodada. Mode 2 → espera_nova (nova_jogada=1) → registra → grava → last round? fim_ganhou : prox_rodada → espera_jogada, with no presentation for rounds ≥2.
- Mode 2, round 16: the new value is written to address 0 (wrap-around); memory still writes; game ends won.
- Timeout in espera_jogada/espera_nova → fim_timeout; db_timeout=1.
- Final states: pronto=1; ganhou=1 (D) or perdeu=1 (E, F); outputs held until iniciar edge → preparacao (new game) or reset.
- iniciar is ignored outside inicial and final states.

Test Plan:
- Mode 1, nivel_jogadas=0: after each presentation, enter mem[0..r-1] for r=1..8 → ganhou=1, pronto=1, rodada=7, state D.
- Mode 1, nivel_jogadas=1: 16 correct rounds → ganhou=1, db_rodada=F, db_nivel_jogadas=1.
- Mode 1, level 1: 6 correct rounds, then in round 7 press 0010 where mem[0]≠0010 → perdeu=1, state E, db_jogada=2.
- Mode 2, level 1: round 1 shows mem[0]; each round enter the sequence plus a new value → memory rewritten at 1..15 (and 0 at the end), ganhou=1.
- Mode 2: 6 correct rounds, then a wrong play → perdeu=1, pronto=1.
- No press in espera_jogada for 5·CLOCK_FREQ cycles (nivel_tempo=0) → db_timeout=1, state F. Apply reset mid-game → state 0 and all outputs 0.
